// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply/divide unit for the Execute stage.
//               Owns the HI/LO registers and executes mult/multu/div/divu.
//               Raises busy (and stallD when a HI/LO reader sits in Decode)
//               while an operation is in flight.
//               Optional build macro: MULDIV_FAST_MUL_EN -- multiplies use a
//               single-cycle combinational product instead of iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,      // synchronous, active-low
    input  logic             startE,
    input  logic [1:0]       opE,        // 00 mult, 01 multu, 10 div, 11 divu
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             hiloreadD,
    output logic             busy,
    output logic             stallD,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FIX   = 2'd2;
    localparam int         c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic [c_CNT_W-1:0] r_count;

    // Shared accumulator: upper half = product high / partial remainder,
    // lower half = multiplier being shifted out / quotient being shifted in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opB;      // multiplicand or divisor magnitude
    logic               r_isDiv;
    logic               r_negRes;   // product / quotient must be negated
    logic               r_negRem;   // remainder takes the dividend's sign
    logic               r_divZero;
    logic [WIDTH-1:0]   r_rawA;     // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_launch;
    logic               w_opSigned;
    logic               w_opDiv;
    logic               w_negA;
    logic               w_negB;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;

    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulStep;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divDiff;
    logic               w_borrow;
    logic [2*WIDTH-1:0] w_divStep;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // A launch is only honoured from IDLE; a flushed Execute slot never launches.
    assign w_launch   = (r_state == c_IDLE) & startE & ~flushE;
    assign w_opSigned = ~opE[0];
    assign w_opDiv    = opE[1];
    assign w_negA     = w_opSigned & srcaE[WIDTH-1];
    assign w_negB     = w_opSigned & srcbE[WIDTH-1];
    // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_absA     = w_negA ? -srcaE : srcaE;
    assign w_absB     = w_negB ? -srcbE : srcbE;

    // Shift-add step: conditionally add multiplicand to the top half, then shift right with carry.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opB : {WIDTH{1'b0}})};
    assign w_mulStep = {w_mulSum, r_acc[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder, trial-subtract.
    assign w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_divDiff  = w_divShift - {1'b0, r_opB};
    assign w_borrow   = w_divDiff[WIDTH];
    assign w_divStep  = {(w_borrow ? w_divShift[WIDTH-1:0] : w_divDiff[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], ~w_borrow};

    // Sign correction applied in FIX.
    assign w_prod = r_negRes ? -r_acc : r_acc;
    assign w_quot = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fastProd;
    assign w_fastProd = {{WIDTH{1'b0}}, w_absA} * {{WIDTH{1'b0}}, w_absB};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> RUN (or FIX for fast multiplies) -> FIX -> IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_launch) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_nextState = w_opDiv ? c_RUN : c_FIX;
`else
                    w_nextState = c_RUN;
`endif
                end
            end
            c_RUN: begin
                if (r_count == '0) begin
                    w_nextState = c_FIX;
                end
            end
            c_FIX:   w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        busy   = (r_state != c_IDLE);
        done   = (r_state == c_FIX);
        stallD = (r_state != c_IDLE) & hiloreadD;
    end

    // Datapath: operand capture at launch, one radix-2 step per RUN cycle, result write in FIX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_opB     <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_rawA    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_launch) begin
                        r_isDiv   <= w_opDiv;
                        r_negRes  <= w_negA ^ w_negB;
                        r_negRem  <= w_negA;
                        r_divZero <= (srcbE == '0);
                        r_rawA    <= srcaE;
                        r_count   <= c_CNT_W'(WIDTH - 1);
                        if (w_opDiv) begin
                            r_acc <= {{WIDTH{1'b0}}, w_absA};
                            r_opB <= w_absB;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            r_acc <= w_fastProd;
`else
                            r_acc <= {{WIDTH{1'b0}}, w_absB};
`endif
                            r_opB <= w_absA;
                        end
                    end
                end
                c_RUN: begin
                    r_acc <= r_isDiv ? w_divStep : w_mulStep;
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end
                end
                c_FIX: begin
                    if (r_isDiv) begin
                        if (r_divZero) begin
                            r_lo <= {WIDTH{1'b1}};
                            r_hi <= r_rawA;
                        end else begin
                            r_lo <= w_quot;
                            r_hi <= w_rem;
                        end
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = W + 1;
`endif
    localparam int DIV_CYC = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         startE = 1'b0;
    logic [1:0]   opE = 2'b00;
    logic [W-1:0] srcaE = '0;
    logic [W-1:0] srcbE = '0;
    logic         flushE = 1'b0;
    logic         hiloreadD = 1'b0;
    logic         busy;
    logic         stallD;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] prevHi = '0;
    logic [W-1:0] prevLo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .startE    (startE),
        .opE       (opE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .flushE    (flushE),
        .hiloreadD (hiloreadD),
        .busy      (busy),
        .stallD    (stallD),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op, measure cycles to done, check HI/LO hold then update.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo, input int expCyc);
        int cyc;
        opE = op; srcaE = a; srcbE = b; startE = 1'b1;
        tick();
        startE = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_doneCycle"}, 64'(cyc), 64'(expCyc));
        chk({tag, "_hiHeld"}, 64'(hi), 64'(prevHi));
        chk({tag, "_loHeld"}, 64'(lo), 64'(prevLo));
        tick();
        chk({tag, "_hi"}, 64'(hi), 64'(expHi));
        chk({tag, "_lo"}, 64'(lo), 64'(expLo));
        chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
        prevHi = expHi;
        prevLo = expLo;
    endtask

    initial begin
        // Reset held low for two cycles.
        reset = 1'b0;
        tick();
        tick();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stallD", 64'(stallD), 64'd0);
        reset = 1'b1;
        tick();

        runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_CYC);
        runOp("mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_CYC);
        runOp("mult_minxmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_CYC);
        runOp("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC);
        runOp("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC);
        runOp("div_5d0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DIV_CYC);
        runOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_CYC);

        // Flushed launch must not start anything.
        opE = 2'b11; srcaE = 32'd50; srcbE = 32'd5; startE = 1'b1; flushE = 1'b1;
        tick();
        startE = 1'b0; flushE = 1'b0;
        chk("flush_busy0", 64'(busy), 64'd0);
        tick();
        chk("flush_busy1", 64'(busy), 64'd0);
        chk("flush_lo", 64'(lo), 64'(prevLo));

        // Stall tracks busy while a reader sits in Decode; a second start during busy is ignored.
        hiloreadD = 1'b1;
        opE = 2'b11; srcaE = 32'd1000; srcbE = 32'd10; startE = 1'b1;
        tick();
        startE = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            chk($sformatf("stallD_c%0d", c), 64'(stallD), 64'(c <= W + 1));
            if (c == 3) begin
                opE = 2'b11; srcaE = 32'd9; srcbE = 32'd2;
            end
            startE = (c == 3);
            tick();
        end
        startE = 1'b0;
        hiloreadD = 1'b0;
        chk("stall_hi", 64'(hi), 64'd0);
        chk("stall_lo", 64'(lo), 64'd100);
        chk("stall_idle", 64'(busy), 64'd0);

        // Reset held low across an active divide.
        opE = 2'b10; srcaE = 32'd100; srcbE = 32'd3; startE = 1'b1;
        tick();
        startE = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midop_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < W + 4; i++) tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
